// File: rtl/chan_512_packet_capture_ctrl.sv
`default_nettype none
// ============================================================================
// chan_512_packet_capture_ctrl : frame-aligned ping-pong capture sequencer
// Optional feature macro: CAPTURE_CTRL_DROP_CNT_EN (dropped-frame counter)
// Revision: 1.0
// ============================================================================
module chan_512_packet_capture_ctrl #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 512,
  parameter int ADDR_W    = 10
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       start_reg,
  input  logic              sync_in,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_din,
  output logic [1:0]        half_ready,
  input  logic [1:0]        half_ack,
  output logic              busy,
  output logic              sync_err,
  output logic [31:0]       status
);

  localparam int CH_W = $clog2(FRAME_LEN);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                run_q, run_d;
  logic                h_q, h_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                buf_we_q, buf_we_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]   buf_din_q, buf_din_d;
  logic [1:0]          half_ready_q, half_ready_d;
  logic                sync_err_q, sync_err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]         drop_cnt;

  logic                run_rise;
  logic                sync_hit;
  logic                clr;
  logic [1:0]          set_mask;
  logic                frame_inc;
  logic                drop_inc;
  logic                err_set;
  logic                unused_start_bits;

  assign run_rise          = start_reg[0] & ~run_q;
  assign sync_hit          = sync_in & data_valid;
  assign clr               = start_reg[1];
  assign unused_start_bits = ^start_reg[31:2];

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    ch_d       = ch_q;
    buf_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_din_d  = buf_din_q;
    set_mask   = 2'b00;
    frame_inc  = 1'b0;
    drop_inc   = 1'b0;
    err_set    = 1'b0;
    run_d      = start_reg[0];

    case (state_q)
      IDLE: begin
        if (run_rise) begin
          state_d = WAIT_SYNC;
        end
      end

      WAIT_SYNC: begin
        if (!start_reg[0]) begin
          state_d = IDLE;
        end else if (sync_hit) begin
          if (!half_ready_q[h_q]) begin
            buf_we_d   = 1'b1;
            buf_addr_d = {h_q, {CH_W{1'b0}}};
            buf_din_d  = data_in;
            ch_d       = CH_W'(1);
            state_d    = FILL;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end

      FILL: begin
        if (data_valid) begin
          buf_we_d  = 1'b1;
          buf_din_d = data_in;
          if (sync_in && (ch_q != '0)) begin
            // Unexpected sync: restart the frame in the same half.
            err_set    = 1'b1;
            buf_addr_d = {h_q, {CH_W{1'b0}}};
            ch_d       = CH_W'(1);
          end else begin
            buf_addr_d = {h_q, ch_q};
            if (ch_q == LAST_CH) begin
              set_mask[h_q] = 1'b1;
              h_d           = ~h_q;
              ch_d          = '0;
              frame_inc     = 1'b1;
              state_d       = start_reg[0] ? WAIT_SYNC : IDLE;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Set takes priority over an ack landing on the same half.
    half_ready_d = (half_ready_q & ~half_ack) | set_mask;

    if (clr) begin
      frame_cnt_d = 16'd0;
      sync_err_d  = 1'b0;
    end else begin
      frame_cnt_d = frame_cnt_q + {15'd0, frame_inc};
      sync_err_d  = sync_err_q | err_set;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      h_q          <= 1'b0;
      ch_q         <= '0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_din_q    <= '0;
      half_ready_q <= 2'b00;
      sync_err_q   <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      h_q          <= h_d;
      ch_q         <= ch_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_din_q    <= buf_din_d;
      half_ready_q <= half_ready_d;
      sync_err_q   <= sync_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

`ifdef CAPTURE_CTRL_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      drop_cnt_d = 16'd0;
    end else if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop_inc;
  assign unused_drop_inc = drop_inc;
  assign drop_cnt        = 16'd0;
`endif

  assign buf_we     = buf_we_q;
  assign buf_addr   = buf_addr_q;
  assign buf_din    = buf_din_q;
  assign half_ready = half_ready_q;
  assign busy       = (state_q != IDLE);
  assign sync_err   = sync_err_q;
  assign status     = {drop_cnt, frame_cnt_q};

endmodule
`default_nettype wire
